// File: rtl/vliw_fetch_unit_pkg.sv
// Shared fetch-pipeline definitions: reset/vector constants and the redirect-cause encoding.
package vliw_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0100;
    localparam int unsigned PC_STEP_DEF    = 4;

    typedef enum logic [1:0] {
        CauseSeq    = 2'd0,
        CauseBranch = 2'd1,
        CauseJump   = 2'd2,
        CauseExc    = 2'd3
    } redirect_cause_e;

    // Priority: exception > jump > taken branch > sequential.
    function automatic redirect_cause_e redirect_cause(input logic exc, input logic jump,
                                                       input logic branch);
        if (exc) begin
            return CauseExc;
        end else if (jump) begin
            return CauseJump;
        end else if (branch) begin
            return CauseBranch;
        end
        return CauseSeq;
    endfunction

endpackage

// File: rtl/vliw_fetch_unit_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush; head reads as zero when empty.
module vliw_fetch_unit_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/vliw_fetch_unit.sv
// VLIW instruction fetch: PC/redirect select, imem request gating, epoch-tagged
// response capture into a prefetch FIFO, valid/ready output to decode.
module vliw_fetch_unit
    import vliw_fetch_unit_pkg::*;
#(
    parameter int unsigned SLOT_W     = 16,
    parameter int unsigned NUM_SLOTS  = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int unsigned PC_STEP    = PC_STEP_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_fetch_en,
    input  logic                          i_branch_taken,
    input  logic [31:0]                   i_branch_target,
    input  logic                          i_jump,
    input  logic [31:0]                   i_jump_target,
    input  logic                          i_exception,
    output logic                          o_imem_req,
    output logic [31:0]                   o_imem_addr,
    input  logic [SLOT_W*NUM_SLOTS-1:0]   i_imem_rdata,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [SLOT_W*NUM_SLOTS-1:0]   o_out_bundle,
    output logic [31:0]                   o_out_pc,
    output logic [31:0]                   o_fetch_pc
);

    localparam int unsigned BW = SLOT_W * NUM_SLOTS;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

    logic [31:0]     r_pc;
    logic            r_epoch;
    logic            r_inflight;
    logic            r_inflight_epoch;
    logic [31:0]     r_req_pc;

    redirect_cause_e w_cause;
    logic            w_redirect;
    logic [31:0]     w_target;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occupancy;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic [BW+31:0]  w_head;

    assign w_cause    = redirect_cause(i_exception, i_jump, i_branch_taken);
    assign w_redirect = (w_cause != CauseSeq);

    always_comb begin
        w_target = r_pc;
        unique case (w_cause)
            CauseExc:    w_target = EXC_VECTOR;
            CauseJump:   w_target = i_jump_target;
            CauseBranch: w_target = i_branch_target;
            default:     w_target = r_pc;
        endcase
    end

    // Counting the in-flight fetch guarantees its response always has a free slot.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_req       = i_fetch_en & ~i_reset & ~w_redirect & (w_occupancy < DEPTH_L);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc             <= RESET_PC;
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_req_pc         <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_epoch <= r_epoch;
                r_req_pc         <= r_pc;
            end
            if (w_redirect) begin
                r_pc    <= w_target;
                r_epoch <= ~r_epoch;
            end else if (w_req) begin
                r_pc <= r_pc + 32'(PC_STEP);
            end
        end
    end

    // Flush inside the FIFO overrides a push that lands in a redirect cycle.
    assign w_push = r_inflight & (r_inflight_epoch == r_epoch);
    assign w_pop  = o_out_valid & i_out_ready;

    vliw_fetch_unit_fetch_fifo #(
        .WIDTH (BW + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_wdata ({r_req_pc, i_imem_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign o_imem_req   = w_req;
    assign o_imem_addr  = r_pc;
    assign o_fetch_pc   = r_pc;
    assign o_out_valid  = (w_count != '0);
    assign o_out_bundle = w_head[BW-1:0];
    assign o_out_pc     = w_head[BW+31:BW];

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Directed bench for vliw_fetch_unit with a one-cycle-latency instruction memory model.
module tb_vliw_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bundle;
    logic [31:0] out_pc;
    logic [31:0] fetch_pc;

    int checks = 0;
    int errors = 0;
    logic seen80 = 1'b0;

    vliw_fetch_unit dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_fetch_en      (fetch_en),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_exception     (exception),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_rdata    (imem_rdata),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_bundle    (out_bundle),
        .o_out_pc        (out_pc),
        .o_fetch_pc      (fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hBEEF, addr[15:0]};
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_f(imem_addr);
        if (out_valid && out_pc == 32'h80) seen80 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
        exception = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_bundle", out_bundle, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);

        // Sequential streaming from reset release.
        #10; reset = 1'b0; out_ready = 1'b1; #1;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 32'h0);
        tick(); #1;
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", out_valid, 0);
        tick(); #1;
        chk("c2_valid", out_valid, 1);
        chk("c2_pc", out_pc, 32'h0);
        chk("c2_bundle", out_bundle, mem_f(32'h0));
        chk("c2_addr", imem_addr, 32'h8);
        tick(); #1;
        chk("c3_pc", out_pc, 32'h4);
        tick(); #1;
        chk("c4_pc", out_pc, 32'h8);
        chk("c4_bundle", out_bundle, mem_f(32'h8));

        // Fill with ready low, then push+pop at count = depth-1.
        out_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("full_req", imem_req, 0);
        chk("full_fetch_pc", fetch_pc, 32'h10);
        chk("full_valid", out_valid, 1);
        chk("full_pc", out_pc, 32'h0);
        tick(); out_ready = 1'b1; #1;
        chk("d6_pc", out_pc, 32'h0);
        tick(); out_ready = 1'b0; #1;
        chk("d7_pc", out_pc, 32'h4);
        chk("d7_req", imem_req, 1);
        chk("d7_addr", imem_addr, 32'h10);
        tick(); out_ready = 1'b1; #1;
        chk("d8_pc", out_pc, 32'h4);
        chk("d8_req", imem_req, 0);
        tick(); #1;
        chk("d9_pc", out_pc, 32'h8);
        chk("d9_addr", imem_addr, 32'h14);
        tick(); #1;
        chk("d10_pc", out_pc, 32'hC);
        tick(); #1;
        chk("d11_pc", out_pc, 32'h10);
        chk("d11_bundle", out_bundle, mem_f(32'h10));
        tick(); #1;
        chk("d12_pc", out_pc, 32'h14);

        // Taken branch with 3 buffered and 1 in flight.
        out_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 4; i++) tick();
        branch_taken = 1'b1; branch_target = 32'h200; #1;
        chk("br_req", imem_req, 0);
        chk("br_valid", out_valid, 1);
        tick(); branch_taken = 1'b0; #1;
        chk("br1_valid", out_valid, 0);
        chk("br1_fetch_pc", fetch_pc, 32'h200);
        chk("br1_addr", imem_addr, 32'h200);
        tick(); #1;
        chk("br2_valid", out_valid, 0);
        tick(); #1;
        chk("br3_valid", out_valid, 1);
        chk("br3_pc", out_pc, 32'h200);
        chk("br3_bundle", out_bundle, mem_f(32'h200));

        // Exception and jump together: exception wins.
        exception = 1'b1; jump = 1'b1; jump_target = 32'h80; #1;
        chk("exc_req", imem_req, 0);
        tick(); exception = 1'b0; jump = 1'b0; #1;
        chk("exc_fetch_pc", fetch_pc, 32'h100);
        chk("exc_valid", out_valid, 0);
        tick(); #1;
        chk("exc2_valid", out_valid, 0);
        tick(); out_ready = 1'b1; #1;
        chk("exc3_pc", out_pc, 32'h100);
        tick(); #1;
        chk("exc4_pc", out_pc, 32'h104);

        // PC wrap at the top of the address space.
        jump = 1'b1; jump_target = 32'hFFFF_FFFC; #1;
        tick(); jump = 1'b0; #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_addr1", imem_addr, 32'h0);
        tick(); #1;
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        chk("wrap_bundle", out_bundle, mem_f(32'hFFFF_FFFC));
        tick(); #1;
        chk("wrap_pc1", out_pc, 32'h0);

        // Fill, then asynchronous reset between edges.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("af_valid", out_valid, 1);
        chk("af_req", imem_req, 0);
        chk("af_fetch_pc", fetch_pc, 32'h10);
        #3; reset = 1'b1; #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_fetch_pc", fetch_pc, 32'h0);
        chk("ar_out_pc", out_pc, 32'h0);
        #1; reset = 1'b0; out_ready = 1'b1; #1;
        chk("ar_req", imem_req, 1);
        chk("ar_addr", imem_addr, 32'h0);
        tick(); #1;
        chk("ar1_addr", imem_addr, 32'h4);
        tick(); #1;
        chk("ar2_valid", out_valid, 1);
        chk("ar2_pc", out_pc, 32'h0);

        chk("no_jump_bundle", {63'b0, seen80}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
